// File: rtl/conv_window_sequencer_if.sv
// ----------------------------------------------------------------------------
// conv_window_sequencer_if: frame, Conv and result signals of the window sequencer (o_class with CONV_SEQ_ARGMAX_EN)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface conv_window_sequencer_if #(
   parameter int N_CH  = 4,
   parameter int WIN   = 10,
   parameter int DW    = 16,
   parameter int OW    = 24,
   parameter int N_OUT = 3
);
   logic                          i_clear;
   logic                          i_frame_valid;
   logic                          o_frame_ready;
   logic [N_CH-1:0][DW-1:0]       i_frame;
   logic                          o_conv_start;
   logic [N_CH*WIN-1:0][DW-1:0]   o_conv_data;
   logic [N_OUT-1:0][OW-1:0]      i_conv_out;
   logic                          o_res_valid;
   logic                          i_res_ready;
   logic [N_OUT-1:0][OW-1:0]      o_res;
   logic                          o_busy;
`ifdef CONV_SEQ_ARGMAX_EN
   logic [$clog2(N_OUT)-1:0]      o_class;
`endif

   modport master (
`ifdef CONV_SEQ_ARGMAX_EN
      output o_class,
`endif
      input  i_clear, i_frame_valid, i_frame, i_conv_out, i_res_ready,
      output o_frame_ready, o_conv_start, o_conv_data, o_res_valid, o_res, o_busy
   );

   modport slave (
`ifdef CONV_SEQ_ARGMAX_EN
      input  o_class,
`endif
      output i_clear, i_frame_valid, i_frame, i_conv_out, i_res_ready,
      input  o_frame_ready, o_conv_start, o_conv_data, o_res_valid, o_res, o_busy
   );
endinterface

`default_nettype wire

// File: rtl/conv_window_sequencer.sv
// ----------------------------------------------------------------------------
// conv_window_sequencer: sliding-window launcher for Conv; CONV_SEQ_ARGMAX_EN adds o_class
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module conv_window_sequencer #(
   parameter int N_CH     = 4,
   parameter int WIN      = 10,
   parameter int HOP      = 5,
   parameter int DW       = 16,
   parameter int OW       = 24,
   parameter int N_OUT    = 3,
   parameter int CONV_LAT = 20
) (
   input  wire logic               i_clk,
   input  wire logic               i_rst_n,
   conv_window_sequencer_if.master bus
);
   localparam int FW = $clog2(WIN + 1);
   localparam int HW = $clog2(HOP + 1);
   localparam int RW = $clog2(CONV_LAT);
   localparam logic [FW-1:0] c_WIN      = FW'(WIN);
   localparam logic [HW-1:0] c_HOP      = HW'(HOP);
   localparam logic [RW-1:0] c_RUN_LAST = RW'(CONV_LAT - 1);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_RUN  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t                        r_state;
   logic [FW-1:0]                 r_fill_cnt;
   logic [HW-1:0]                 r_hop_cnt;
   logic [RW-1:0]                 r_run_cnt;
   logic [N_CH*WIN-1:0][DW-1:0]   r_window;
   logic [N_OUT-1:0][OW-1:0]      r_res;
   logic                          r_frame_ready;
   logic                          r_conv_start;
   logic                          r_res_valid;
   logic                          r_busy;

   logic          w_accept;
   logic          w_launch;
   logic [FW-1:0] w_fill_inc;
   logic [HW-1:0] w_hop_inc;

   // r_frame_ready is only ever high in FILL, so it doubles as the state qualifier
   assign w_accept   = bus.i_frame_valid && r_frame_ready;
   assign w_fill_inc = (r_fill_cnt == c_WIN) ? c_WIN : r_fill_cnt + FW'(1);
   assign w_hop_inc  = (r_hop_cnt == c_HOP) ? c_HOP : r_hop_cnt + HW'(1);
   assign w_launch   = w_accept &&
                       ((r_fill_cnt == c_WIN - FW'(1)) ||
                        ((r_fill_cnt == c_WIN) && (w_hop_inc == c_HOP)));

`ifdef CONV_SEQ_ARGMAX_EN
   localparam int CW = $clog2(N_OUT);
   logic [CW-1:0]        r_class;
   logic [CW-1:0]        w_class;
   logic signed [OW-1:0] w_best;

   // strict greater-than keeps the lowest index on ties
   always_comb begin
      w_class = '0;
      w_best  = bus.i_conv_out[0];
      for (int i = 1; i < N_OUT; i++) begin
         if ($signed(bus.i_conv_out[i]) > w_best) begin
            w_best  = bus.i_conv_out[i];
            w_class = CW'(i);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_class <= '0;
      else if (!bus.i_clear && r_state == S_RUN && r_run_cnt == c_RUN_LAST)
         r_class <= w_class;
   end

   assign bus.o_class = r_class;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_FILL;
         r_fill_cnt    <= '0;
         r_hop_cnt     <= '0;
         r_run_cnt     <= '0;
         r_window      <= '0;
         r_res         <= '0;
         r_frame_ready <= 1'b0;
         r_conv_start  <= 1'b0;
         r_res_valid   <= 1'b0;
         r_busy        <= 1'b0;
      end else if (bus.i_clear) begin
         r_state       <= S_FILL;
         r_fill_cnt    <= '0;
         r_hop_cnt     <= '0;
         r_run_cnt     <= '0;
         r_window      <= '0;
         r_frame_ready <= 1'b1;
         r_conv_start  <= 1'b0;
         r_res_valid   <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               r_frame_ready <= 1'b1;
               if (w_accept) begin
                  for (int c = 0; c < N_CH; c++) begin
                     for (int t = 0; t < WIN - 1; t++)
                        r_window[c*WIN + t] <= r_window[c*WIN + t + 1];
                     r_window[c*WIN + WIN - 1] <= bus.i_frame[c];
                  end
                  r_fill_cnt <= w_fill_inc;
                  if (w_launch) begin
                     r_hop_cnt     <= '0;
                     r_run_cnt     <= '0;
                     r_state       <= S_RUN;
                     r_frame_ready <= 1'b0;
                     r_conv_start  <= 1'b1;
                     r_busy        <= 1'b1;
                  end else begin
                     r_hop_cnt <= w_hop_inc;
                  end
               end
            end
            S_RUN: begin
               if (r_run_cnt == c_RUN_LAST) begin
                  r_res        <= bus.i_conv_out;
                  r_conv_start <= 1'b0;
                  r_res_valid  <= 1'b1;
                  r_state      <= S_OUT;
               end else begin
                  r_run_cnt <= r_run_cnt + RW'(1);
               end
            end
            S_OUT: begin
               if (bus.i_res_ready) begin
                  r_res_valid   <= 1'b0;
                  r_frame_ready <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= S_FILL;
               end
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign bus.o_frame_ready = r_frame_ready;
   assign bus.o_conv_start  = r_conv_start;
   assign bus.o_conv_data   = r_window;
   assign bus.o_res_valid   = r_res_valid;
   assign bus.o_res         = r_res;
   assign bus.o_busy        = r_busy;

endmodule

`default_nettype wire
